// File: rtl/physical_transmitter.sv
// QPSK framer/modulator: SOF preamble + payload symbols mapped to signed 12-bit I/Q,
// each symbol held for SPS samples (rectangular NRZ). Output word is {I, Q}.
module physical_transmitter #(
  parameter int unsigned        SPS         = 8,
  parameter logic signed [11:0] AMP         = 12'sd1024,
  parameter int unsigned        PAYLOAD_LEN = 63,
  parameter int unsigned        GAP_SYMS    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        underflow
);

  localparam int unsigned CntW   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [25:0] SofI   = 26'h3278428;
  localparam logic [25:0] SofQ   = 26'h272d17d;
  localparam logic [11:0] PosAmp = AMP;
  localparam logic [11:0] NegAmp = 12'(-AMP);

  typedef enum logic [1:0] {StIdle, StSof, StPayload, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [6:0]        sym_cnt_q, sym_cnt_d;
  logic [23:0]       out_data_q, out_data_d;
  logic              out_valid_q;
  logic              busy_q;
  logic              underflow_q, underflow_d;

  logic       xfer, last_sample, boundary;
  logic       sof_last, pay_last, gap_last, next_is_payload, frame_end;
  logic [4:0] sof_idx;
  logic [1:0] sym;

  assign xfer            = out_valid_q & out_ready;
  assign last_sample     = (sample_cnt_q == CntW'(SPS - 1));
  assign boundary        = xfer & last_sample;
  assign sof_last        = (sym_cnt_q == 7'd25);
  assign pay_last        = (sym_cnt_q == 7'(PAYLOAD_LEN - 1));
  assign gap_last        = (sym_cnt_q == 7'(GAP_SYMS - 1));
  assign next_is_payload = ((state_q == StSof) & sof_last) | ((state_q == StPayload) & ~pay_last);
  // Reset in the same cycle suppresses the fetch so nothing is consumed.
  assign in_ready        = boundary & next_is_payload & ~rst;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    out_data_d   = out_data_q;
    underflow_d  = 1'b0;
    frame_end    = 1'b0;
    sof_idx      = 5'd0;
    sym          = 2'b00;

    if (xfer) begin
      sample_cnt_d = last_sample ? '0 : sample_cnt_q + 1'b1;
    end

    if (boundary) begin
      sym_cnt_d = sym_cnt_q + 7'd1;
      unique case (state_q)
        StIdle: begin
          sym_cnt_d = 7'd0;
          if (in_valid) state_d = StSof;
        end
        StSof: begin
          if (sof_last) begin
            state_d   = StPayload;
            sym_cnt_d = 7'd0;
          end
        end
        StPayload: frame_end = pay_last;
        StGap:     frame_end = gap_last;
        default:   state_d = StIdle;
      endcase

      if (frame_end) begin
        sym_cnt_d = 7'd0;
        if ((GAP_SYMS != 0) && (state_q == StPayload)) state_d = StGap;
        else if (in_valid)                             state_d = StSof;
        else                                           state_d = StIdle;
      end

      // Entering or staying in payload is always a fetch slot.
      unique case (state_d)
        StSof: begin
          sof_idx    = 5'(7'd25 - sym_cnt_d);
          out_data_d = {SofI[sof_idx] ? PosAmp : NegAmp, SofQ[sof_idx] ? PosAmp : NegAmp};
        end
        StPayload: begin
          sym         = in_valid ? in_data : 2'b00;
          underflow_d = ~in_valid;
          out_data_d  = {sym[1] ? NegAmp : PosAmp, sym[0] ? NegAmp : PosAmp};
        end
        default: out_data_d = 24'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      sym_cnt_q    <= 7'd0;
      out_data_q   <= 24'd0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= 1'b1;
      busy_q       <= (state_d != StIdle);
      underflow_q  <= underflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_physical_transmitter.sv
// Directed bench for physical_transmitter: idle, single frame, backpressure, underflow,
// back-to-back frames and mid-frame reset, with hand-built expected sample streams.
module tb_physical_transmitter;

  localparam int Sps = 8;
  localparam int Pay = 63;
  localparam int FrameSyms = 26 + Pay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'b00;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        underflow;

  physical_transmitter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          cyc, slot, total, drop_lo, drop_hi, pat;
  bit          bp_en, seen_busy, last_busy, prev_stall, timed_out;
  int          busy_cnt, uf_cnt, hold_err;
  logic [23:0] prev_data;
  logic [23:0] cap[$];
  int          ir_cyc[$];

  function automatic logic [1:0] src_sym(int s);
    return (pat == 0) ? 2'(s % 4) : 2'((s / 3 + s) % 4);
  endfunction

  function automatic logic [23:0] sof_word(int k);
    logic [25:0] si;
    logic [25:0] sq;
    si = 26'h3278428;
    sq = 26'h272d17d;
    return {si[25-k] ? 12'h400 : 12'hC00, sq[25-k] ? 12'h400 : 12'hC00};
  endfunction

  function automatic logic [23:0] pay_word(logic [1:0] d);
    return {d[1] ? 12'hC00 : 12'h400, d[0] ? 12'hC00 : 12'h400};
  endfunction

  function automatic logic [23:0] exp_word(int i);
    int s, k, sl;
    s  = i / Sps;
    k  = s % FrameSyms;
    sl = (s / FrameSyms) * Pay + (k - 26);
    if (k < 26) return sof_word(k);
    if (sl >= drop_lo && sl <= drop_hi) return 24'h400400;
    return pay_word(src_sym(sl));
  endfunction

  task automatic drive();
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid  = (slot < total) && !(slot >= drop_lo && slot <= drop_hi);
    in_data   = src_sym(slot);
  endtask

  task automatic step();
    bit ir;
    @(negedge clk);
    if (out_valid && out_ready && busy) cap.push_back(out_data);
    if (prev_stall && out_data !== prev_data) hold_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (busy) begin busy_cnt++; seen_busy = 1'b1; end
    last_busy = busy;
    if (underflow) uf_cnt++;
    ir = in_ready;
    if (ir) ir_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (ir) slot++;
    drive();
  endtask

  task automatic start_run(int frames, bit bp);
    total = frames * Pay; slot = 0; bp_en = bp; cyc = 0;
    seen_busy = 0; last_busy = 0; prev_stall = 0; timed_out = 0;
    busy_cnt = 0; uf_cnt = 0; hold_err = 0;
    cap.delete(); ir_cyc.delete();
    drive();
  endtask

  task automatic run_frames(int frames, bit bp);
    start_run(frames, bp);
    while (!(seen_busy && !last_busy)) begin
      if (cyc > 4000 * frames) begin timed_out = 1; break; end
      step();
    end
    repeat (4) step();
    tests++;
    if (timed_out) begin
      fails++;
      $display("FAIL timeout: busy never completed, got %0d busy cycles, need frame end", busy_cnt);
    end
  endtask

  task automatic check_stream(string name, int frames);
    int bad;
    bad = -1;
    for (int i = 0; i < cap.size() && bad < 0; i++) if (cap[i] !== exp_word(i)) bad = i;
    tests++;
    if (cap.size() != frames * FrameSyms * Sps) begin
      fails++;
      $display("FAIL %s_len: got %0d samples, need %0d", name, cap.size(), frames * FrameSyms * Sps);
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s_data: sample %0d got %h, need %h", name, bad, cap[bad], exp_word(bad));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drop_lo = -1; drop_hi = -1; pat = 0; total = 0; slot = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b need 0", out_valid); end
    tests++; if (out_data !== 24'd0) begin fails++; $display("FAIL rst_data: got %h need 0", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b need 0", busy); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL rst_uf: got %b need 0", underflow); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b need 0", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rel_valid: got %b need 1", out_valid); end
  endtask

  task automatic test_idle();
    int bad_v, bad_d, bad_b, bad_r;
    do_reset();
    bad_v = 0; bad_d = 0; bad_b = 0; bad_r = 0;
    @(negedge clk);
    repeat (100) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_v++;
      if (out_data !== 24'd0) bad_d++;
      if (busy !== 1'b0) bad_b++;
      if (in_ready !== 1'b0) bad_r++;
    end
    tests++; if (bad_v != 0) begin fails++; $display("FAIL idle_valid: %0d bad cycles, need 0", bad_v); end
    tests++; if (bad_d != 0) begin fails++; $display("FAIL idle_data: %0d bad cycles, need 0", bad_d); end
    tests++; if (bad_b + bad_r != 0) begin
      fails++; $display("FAIL idle_busy_ready: busy %0d ready %0d cycles, need 0", bad_b, bad_r);
    end
    #1;
  endtask

  task automatic test_single_frame();
    int bad_gap;
    do_reset();
    run_frames(1, 0);
    check_stream("single", 1);
    bad_gap = 0;
    for (int i = 1; i < ir_cyc.size(); i++) if (ir_cyc[i] - ir_cyc[i-1] != Sps) bad_gap++;
    tests++; if (ir_cyc.size() != Pay) begin
      fails++; $display("FAIL single_ready_cnt: got %0d need %0d", ir_cyc.size(), Pay);
    end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL single_ready_gap: %0d bad, need 0", bad_gap); end
    tests++; if (busy_cnt != 712) begin fails++; $display("FAIL single_busy: got %0d need 712", busy_cnt); end
    tests++; if (uf_cnt != 0) begin fails++; $display("FAIL single_uf: got %0d need 0", uf_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_frames(1, 1);
    check_stream("bp", 1);
    tests++; if (hold_err != 0) begin fails++; $display("FAIL bp_hold: %0d changes while stalled, need 0", hold_err); end
    tests++; if (ir_cyc.size() != Pay) begin
      fails++; $display("FAIL bp_ready_cnt: got %0d need %0d", ir_cyc.size(), Pay);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drop_lo = 10; drop_hi = 12;
    run_frames(1, 0);
    check_stream("uf", 1);
    tests++; if (uf_cnt != 3) begin fails++; $display("FAIL uf_pulses: got %0d need 3", uf_cnt); end
    tests++; if (ir_cyc.size() != Pay) begin
      fails++; $display("FAIL uf_ready_cnt: got %0d need %0d", ir_cyc.size(), Pay);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pat = 1;
    run_frames(3, 0);
    check_stream("b2b", 3);
    tests++; if (busy_cnt != 3 * 712) begin
      fails++; $display("FAIL b2b_busy: got %0d need %0d", busy_cnt, 3 * 712);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    do_reset();
    start_run(1, 0);
    guard = 0;
    while (slot < 40 && guard < 4000) begin step(); guard++; end
    repeat (Sps - 1) step();
    rst = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mrst_ready: got %b need 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    tests++; if (out_data !== 24'd0) begin fails++; $display("FAIL mrst_data: got %h need 0", out_data); end
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mrst_state: busy %b valid %b, need 0 0", busy, out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run_frames(1, 0);
    check_stream("restart", 1);
  endtask

  initial begin
    drop_lo = -1; drop_hi = -1; pat = 0;
    test_reset();
    test_idle();
    test_single_frame();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
